// File: rtl/ctrl_pkg.sv
// Shared decode definitions: opcodes, sequencer states and the registered ID/EX control bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  typedef enum logic [0:0] {
    RUN     = ST_RUN,
    MD_WAIT = ST_MD_WAIT
  } state_e;

  typedef struct packed {
    logic [5:0] branch;
    logic       jump;
    logic       reg_write;
    logic [2:0] imm_src;
    logic       a_src;
    logic       b_src;
    logic       pc_target_src;
    logic [3:0] alu_control;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] dqm;
    logic       md_result;
    logic       illegal;
  } ctrl_bundle_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ALUDecoder.sv
// ALU operation select from ALUOp class and funct fields.
module ALUDecoder (
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [3:0] ALUControl
);

  always_comb begin
    ALUControl = 4'b0000;
    case (ALUOp)
      2'b01: begin
        case (funct3[2:1])
          2'b10:   ALUControl = 4'b0010;
          2'b11:   ALUControl = 4'b0011;
          default: ALUControl = 4'b1000;
        endcase
      end
      // bit 3 selects sub (R-type only) or arithmetic right shift
      2'b10: ALUControl = {((funct3 == 3'b000) && opb5 && funct7b5) ||
                           ((funct3 == 3'b101) && funct7b5), funct3};
      default: ALUControl = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mainDecoder.sv
// Opcode-level decode into datapath control fields; flags opcodes it does not recognise.
module mainDecoder
  import ctrl_pkg::*;
(
  input  logic [6:0] OPCode,
  input  logic [2:0] funct3,
  output logic [5:0] branch,
  output logic       jump,
  output logic       regWrite,
  output logic [2:0] immSrc,
  output logic       ASrc,
  output logic       BSrc,
  output logic       PCTargetSrc,
  output logic [1:0] ALUOp,
  output logic       memWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] DQM,
  output logic       illegal
);

  always_comb begin
    branch      = '0;
    jump        = 1'b0;
    regWrite    = 1'b0;
    immSrc      = 3'd0;
    ASrc        = 1'b0;
    BSrc        = 1'b0;
    PCTargetSrc = 1'b0;
    ALUOp       = 2'b00;
    memWrite    = 1'b0;
    resultSrc   = 2'b00;
    DQM         = 2'b00;
    illegal     = 1'b0;
    case (OPCode)
      OP_R: begin
        regWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      OP_I: begin
        regWrite = 1'b1;
        BSrc     = 1'b1;
        ALUOp    = 2'b10;
      end
      OP_LOAD: begin
        regWrite  = 1'b1;
        BSrc      = 1'b1;
        resultSrc = 2'b01;
        DQM       = funct3[1:0];
      end
      OP_STORE: begin
        memWrite = 1'b1;
        BSrc     = 1'b1;
        immSrc   = 3'd1;
        DQM      = funct3[1:0];
      end
      OP_BRANCH: begin
        immSrc = 3'd2;
        ALUOp  = 2'b01;
        // one-hot: beq, bne, blt, bge, bltu, bgeu
        case (funct3)
          3'b000:  branch = 6'b000001;
          3'b001:  branch = 6'b000010;
          3'b100:  branch = 6'b000100;
          3'b101:  branch = 6'b001000;
          3'b110:  branch = 6'b010000;
          3'b111:  branch = 6'b100000;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        jump      = 1'b1;
        regWrite  = 1'b1;
        immSrc    = 3'd3;
        resultSrc = 2'b10;
      end
      OP_JALR: begin
        jump        = 1'b1;
        regWrite    = 1'b1;
        BSrc        = 1'b1;
        PCTargetSrc = 1'b1;
        resultSrc   = 2'b10;
      end
      OP_LUI: begin
        regWrite  = 1'b1;
        immSrc    = 3'd4;
        resultSrc = 2'b11;
      end
      OP_AUIPC: begin
        regWrite = 1'b1;
        ASrc     = 1'b1;
        BSrc     = 1'b1;
        immSrc   = 3'd4;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences a multi-cycle mul/div operation: start/kill pulses and the latency down-counter.
//   state   | meaning
//   RUN     | accepting instructions, no mul/div outstanding
//   MD_WAIT | mul/div in flight, cnt counts down to result
module muldiv_sequencer
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  input  logic       start,
  input  logic [2:0] funct3,
  output logic       single,
  output logic       complete,
  output logic       busy,
  output logic       mdStart,
  output logic       mdKill,
  output logic [2:0] mdOp
);

  localparam int CW = $clog2(max_int(MUL_LATENCY, DIV_LATENCY)) + 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_m1;

  assign lat_m1   = funct3[2] ? CW'(DIV_LATENCY - 1) : CW'(MUL_LATENCY - 1);
  assign single   = funct3[2] ? (DIV_LATENCY == 1) : (MUL_LATENCY == 1);
  assign complete = (state == MD_WAIT) && (cnt == '0) && !stall && !flush;
  assign busy     = (state == MD_WAIT) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      mdStart <= 1'b0;
      mdKill  <= 1'b0;
      mdOp    <= '0;
    end else if (flush) begin
      mdKill  <= (state == MD_WAIT);
      mdStart <= 1'b0;
      state   <= RUN;
      cnt     <= '0;
    end else begin
      mdKill  <= 1'b0;
      mdStart <= start;
      if (start) mdOp <= funct3;
      case (state)
        RUN: begin
          if (start && !single) begin
            state <= MD_WAIT;
            cnt   <= lat_m1;
          end
        end
        MD_WAIT: begin
          // counter runs through stalls; only the hand-off waits for stall to drop
          if (cnt != '0) cnt <= cnt - CW'(1);
          if ((cnt == '0) && !stall) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered, stall/flush-aware decode stage producing the ID/EX control bundle.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter bit MULDIV_EN   = 1'b1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inValid,
  output logic       inReady,
  input  logic [6:0] OPCode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall,
  input  logic       flush,
  output logic       exValid,
  output logic [5:0] branch,
  output logic       jump,
  output logic       regWrite,
  output logic [2:0] immSrc,
  output logic       ASrc,
  output logic       BSrc,
  output logic       PCTargetSrc,
  output logic [3:0] ALUControl,
  output logic       memWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] DQM,
  output logic       mdResult,
  output logic       mdStart,
  output logic [2:0] mdOp,
  output logic       mdKill,
  output logic       busy,
  output logic       illegal
);

  ctrl_bundle_t dec_b, q;
  logic [1:0]   alu_op;
  logic         dec_illegal;
  logic         md_enc, is_md, ill, accept, md_single, md_complete;

  mainDecoder u_main (
    .OPCode     (OPCode),
    .funct3     (funct3),
    .branch     (dec_b.branch),
    .jump       (),
    .regWrite   (),
    .immSrc     (dec_b.imm_src),
    .ASrc       (dec_b.a_src),
    .BSrc       (dec_b.b_src),
    .PCTargetSrc(dec_b.pc_target_src),
    .ALUOp      (alu_op),
    .memWrite   (),
    .resultSrc  (dec_b.result_src),
    .DQM        (dec_b.dqm),
    .illegal    (dec_illegal)
  );

  ALUDecoder u_alu (
    .ALUOp     (alu_op),
    .funct3    (funct3),
    .funct7b5  (funct7[5]),
    .opb5      (OPCode[5]),
    .ALUControl(dec_b.alu_control)
  );

  assign md_enc  = (OPCode == OP_R) && (funct7 == FUNCT7_MULDIV);
  assign is_md   = md_enc && MULDIV_EN;
  assign ill     = dec_illegal || (md_enc && !MULDIV_EN);
  assign inReady = rst_n && !busy && !stall && !flush;
  assign accept  = inValid && inReady;

  // write-enables are re-derived here so M-ops and illegal encodings can override them
  logic [5:0] raw_branch;
  logic       raw_jump, raw_reg_write, raw_mem_write;

  mainDecoder u_main_we (
    .OPCode     (OPCode),
    .funct3     (funct3),
    .branch     (raw_branch),
    .jump       (raw_jump),
    .regWrite   (raw_reg_write),
    .immSrc     (),
    .ASrc       (),
    .BSrc       (),
    .PCTargetSrc(),
    .ALUOp      (),
    .memWrite   (raw_mem_write),
    .resultSrc  (),
    .DQM        (),
    .illegal    ()
  );

  always_comb begin
    dec_b.jump      = raw_jump;
    dec_b.reg_write = raw_reg_write;
    dec_b.mem_write = raw_mem_write;
    dec_b.md_result = is_md;
    dec_b.illegal   = ill;
    if (is_md) begin
      dec_b.reg_write = 1'b1;
      dec_b.mem_write = 1'b0;
      dec_b.jump      = 1'b0;
    end
    if (ill) begin
      dec_b.reg_write = 1'b0;
      dec_b.mem_write = 1'b0;
      dec_b.jump      = 1'b0;
    end
  end

  logic [5:0] branch_sel;
  assign branch_sel = (is_md || ill) ? 6'b0 : raw_branch;

  muldiv_sequencer #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .flush   (flush),
    .start   (accept && is_md),
    .funct3  (funct3),
    .single  (md_single),
    .complete(md_complete),
    .busy    (busy),
    .mdStart (mdStart),
    .mdKill  (mdKill),
    .mdOp    (mdOp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      exValid <= 1'b0;
    end else if (flush) begin
      exValid     <= 1'b0;
      q.reg_write <= 1'b0;
      q.mem_write <= 1'b0;
      q.branch    <= '0;
      q.jump      <= 1'b0;
      q.md_result <= 1'b0;
      q.illegal   <= 1'b0;
    end else if (busy) begin
      exValid <= md_complete;
    end else if (accept) begin
      q        <= dec_b;
      q.branch <= branch_sel;
      exValid  <= !is_md || md_single;
    end else if (!stall) begin
      exValid     <= 1'b0;
      q.reg_write <= 1'b0;
      q.mem_write <= 1'b0;
      q.branch    <= '0;
      q.jump      <= 1'b0;
      q.md_result <= 1'b0;
      q.illegal   <= 1'b0;
    end
  end

  assign branch      = q.branch;
  assign jump        = q.jump;
  assign regWrite    = q.reg_write;
  assign immSrc      = q.imm_src;
  assign ASrc        = q.a_src;
  assign BSrc        = q.b_src;
  assign PCTargetSrc = q.pc_target_src;
  assign ALUControl  = q.alu_control;
  assign memWrite    = q.mem_write;
  assign resultSrc   = q.result_src;
  assign DQM         = q.dqm;
  assign mdResult    = q.md_result;
  assign illegal     = q.illegal;

endmodule
